// File: rtl/bcd_to_binary_pkg.sv
// -----------------------------------------------------------------------------
// bcd_to_binary_pkg
// Shared definitions for the BCD-to-binary converter and its per-digit
// adjust block: FSM state encoding, BCD digit constants and a digit
// validity helper.
// -----------------------------------------------------------------------------
package bcd_to_binary_pkg;

    // Conversion FSM states; 2'b11 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Largest legal decimal digit.
    localparam logic [3:0] BCD_DIGIT_MAX     = 4'd9;
    // A digit at or above this value after a right shift needs correcting.
    localparam logic [3:0] BCD_ADJ_THRESHOLD = 4'd8;
    // Correction applied to such a digit.
    localparam logic [3:0] BCD_ADJ_VALUE     = 4'd3;

    // True when a 4-bit field does not hold a decimal digit.
    function automatic logic digit_invalid(input logic [3:0] digit);
        logic bad;
        if (digit > BCD_DIGIT_MAX) begin
            bad = 1'b1;
        end else begin
            bad = 1'b0;
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_to_binary_digit_adjust.sv
// -----------------------------------------------------------------------------
// bcd_to_binary_digit_adjust
// Combinational correction of one BCD digit after a right shift: a digit of
// 8 or more has received the half-weight of the digit above it (worth 5 in
// this digit, but shifted in as 8), so 3 is subtracted.
//
// Ports:
//   digit_in   in  4  shifted digit
//   digit_out  out 4  corrected digit
// -----------------------------------------------------------------------------
module bcd_to_binary_digit_adjust
    import bcd_to_binary_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    // Subtract the correction when the threshold is reached.
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= BCD_ADJ_THRESHOLD) begin
            digit_out = digit_in - BCD_ADJ_VALUE;
        end else begin
            digit_out = digit_in;
        end
    end

endmodule

// File: rtl/bcd_to_binary.sv
// -----------------------------------------------------------------------------
// bcd_to_binary
// Sequential reverse double-dabble converter. A packed BCD word is loaded into
// the upper field of a single working register; each SHIFT cycle shifts the
// whole register right by one and corrects every BCD digit, so the binary
// value accumulates in the lower field. Latency is fixed at OUTPUT_WIDTH shift
// cycles regardless of data; an invalid digit short-cuts straight to DONE.
//
// Parameters:
//   DECIMAL_DIGITS  number of packed BCD digits
//   OUTPUT_WIDTH    binary result width and number of shift iterations
//
// Ports:
//   i_Clock   in   1                 clock, rising edge
//   i_Rst_L   in   1                 asynchronous active-low reset
//   i_Start   in   1                 conversion request, sampled only in IDLE
//   i_BCD     in   DECIMAL_DIGITS*4  packed BCD, digit 0 in [3:0]
//   o_Binary  out  OUTPUT_WIDTH      result, held until the next completion
//   o_Busy    out  1                 high in every state but IDLE
//   o_Done    out  1                 one-cycle completion pulse
//   o_Error   out  1                 invalid digit or overflow, held with result
// -----------------------------------------------------------------------------
module bcd_to_binary
    import bcd_to_binary_pkg::*;
#(
    parameter int DECIMAL_DIGITS = 2,
    parameter int OUTPUT_WIDTH   = 7
) (
    input  logic                        i_Clock,
    input  logic                        i_Rst_L,
    input  logic                        i_Start,
    input  logic [DECIMAL_DIGITS*4-1:0] i_BCD,
    output logic [OUTPUT_WIDTH-1:0]     o_Binary,
    output logic                        o_Busy,
    output logic                        o_Done,
    output logic                        o_Error
);

    localparam int BCD_W  = DECIMAL_DIGITS * 4;
    localparam int WORK_W = BCD_W + OUTPUT_WIDTH;
    localparam int CNT_W  = (OUTPUT_WIDTH > 1) ? $clog2(OUTPUT_WIDTH) : 1;

    state_t                    state_r;
    state_t                    state_next_s;
    logic [WORK_W-1:0]         work_r;
    logic [WORK_W-1:0]         work_next_s;
    logic [WORK_W-1:0]         shifted_s;
    logic [WORK_W-1:0]         adjusted_s;
    logic [CNT_W-1:0]          cnt_r;
    logic [CNT_W-1:0]          cnt_next_s;
    logic                      invalid_r;
    logic                      invalid_next_s;
    logic [DECIMAL_DIGITS-1:0] digit_bad_s;
    logic                      any_bad_s;
    logic                      load_result_s;
    logic [OUTPUT_WIDTH-1:0]   binary_r;
    logic                      busy_r;
    logic                      done_r;
    logic                      error_r;

    // Logical right shift of the whole working register; the BCD field's
    // low bit falls into the top of the binary field.
    assign shifted_s = {1'b0, work_r[WORK_W-1:1]};

    // The binary field passes through unchanged; only BCD digits are corrected.
    assign adjusted_s[OUTPUT_WIDTH-1:0] = shifted_s[OUTPUT_WIDTH-1:0];

    genvar g;
    generate
        for (g = 0; g < DECIMAL_DIGITS; g = g + 1) begin : g_digit
            bcd_to_binary_digit_adjust u_adjust (
                .digit_in  (shifted_s[OUTPUT_WIDTH + 4*g +: 4]),
                .digit_out (adjusted_s[OUTPUT_WIDTH + 4*g +: 4])
            );
            assign digit_bad_s[g] = digit_invalid(i_BCD[4*g +: 4]);
        end
    endgenerate

    assign any_bad_s = |digit_bad_s;

    // Next-state and datapath selection for the conversion FSM.
    always_comb begin
        state_next_s   = state_r;
        work_next_s    = work_r;
        cnt_next_s     = cnt_r;
        invalid_next_s = invalid_r;
        load_result_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_Start) begin
                    work_next_s = {i_BCD, {OUTPUT_WIDTH{1'b0}}};
                    cnt_next_s  = CNT_W'(OUTPUT_WIDTH - 1);
                    if (any_bad_s) begin
                        invalid_next_s = 1'b1;
                        state_next_s   = ST_DONE;
                        load_result_s  = 1'b1;
                    end else begin
                        invalid_next_s = 1'b0;
                        state_next_s   = ST_SHIFT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                work_next_s = adjusted_s;
                // The counter reaching zero marks the final shift, which
                // also moves the FSM into DONE on the same edge.
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_next_s  = ST_DONE;
                    load_result_s = 1'b1;
                end else begin
                    cnt_next_s = cnt_r - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, working register and registered outputs.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_r   <= ST_IDLE;
            work_r    <= {WORK_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            invalid_r <= 1'b0;
            binary_r  <= {OUTPUT_WIDTH{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            work_r    <= work_next_s;
            cnt_r     <= cnt_next_s;
            invalid_r <= invalid_next_s;
            busy_r    <= (state_next_s != ST_IDLE);
            done_r    <= (state_next_s == ST_DONE);
            // A nonzero residue in the BCD field after all shifts means the
            // value did not fit; the binary field then holds it modulo 2^W.
            if (load_result_s) begin
                binary_r <= work_next_s[OUTPUT_WIDTH-1:0];
                error_r  <= invalid_next_s | (|work_next_s[WORK_W-1:OUTPUT_WIDTH]);
            end else begin
                binary_r <= binary_r;
                error_r  <= error_r;
            end
        end
    end

    assign o_Binary = binary_r;
    assign o_Busy   = busy_r;
    assign o_Done   = done_r;
    assign o_Error  = error_r;

endmodule
